// File: rtl/prefetch_pkg.sv
// Shared types and constants for the instruction prefetch block.
package prefetch_pkg;

  localparam int PC_STEP = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Sequential fetch address; wraps modulo 2^32.
  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + 32'(PC_STEP);
  endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries; flush beats push and pop.
module prefetch_fifo
  import prefetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty
);

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr];

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetch stage: credit-limited request bus, in-order responses, redirect flush.
// Optional macro FETCH_ALIGN_CHECK_EN adds the sticky fetch_misalign output.
module instr_prefetch
  import prefetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        fetch_valid,
  input  logic        fetch_ready,
  output logic [31:0] fetch_instr,
  output logic [31:0] fetch_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        fetch_misalign
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   req_pc, rsp_pc, tgt_pc;
  logic [CW-1:0] inflight, inflight_nxt, drop, count;
  logic [CW:0]   used;
  logic          misalign;
  logic          req_fire, rsp_take, rsp_drop, push, pop;
  logic          fifo_full, fifo_empty;
  fetch_entry_t  head, push_entry;

  assign tgt_pc = {redirect_pc[31:2], 2'b00};

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst)                                   misalign <= 1'b0;
    else if (redirect && redirect_pc[1:0] != 2'b00) misalign <= 1'b1;
  end
  assign fetch_misalign = misalign;
`else
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^redirect_pc[1:0];
  assign misalign      = 1'b0;
`endif

  // Buffered plus outstanding words never exceed the buffer size, so pushes cannot overflow.
  assign used           = {1'b0, count} + {1'b0, inflight};
  assign imem_req_valid = !rst && !redirect && !misalign && (used < (CW+1)'(DEPTH));
  assign imem_req_addr  = req_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses with nothing outstanding predate a reset and are ignored.
  assign rsp_take     = imem_rsp_valid && (inflight != '0);
  assign rsp_drop     = rsp_take && (drop != '0);
  assign push         = rsp_take && (drop == '0) && !redirect && !misalign && !fifo_full;
  assign pop          = fetch_valid && fetch_ready;
  assign inflight_nxt = inflight + CW'(req_fire) - CW'(rsp_take);

  always_ff @(posedge clk) begin
    if (rst) begin
      req_pc   <= RESET_PC;
      rsp_pc   <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
    end else begin
      inflight <= inflight_nxt;
      if (redirect) begin
        req_pc <= tgt_pc;
        rsp_pc <= tgt_pc;
        // Everything still outstanding belongs to the old path.
        drop   <= inflight_nxt;
      end else begin
        if (req_fire) req_pc <= pc_next(req_pc);
        if (push)     rsp_pc <= pc_next(rsp_pc);
        if (rsp_drop) drop   <= drop - CW'(1);
      end
    end
  end

  assign push_entry = '{pc: rsp_pc, instr: imem_rsp_data};

  prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect),
    .head      (head),
    .count     (count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign fetch_valid = !fifo_empty;
  assign fetch_pc    = head.pc;
  assign fetch_instr = head.instr;

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed bench for instr_prefetch with an in-order fixed-latency bus model.
module tb_instr_prefetch;

  localparam logic [31:0] K = 32'hDEAD_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid, imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        fetch_valid, fetch_ready = 1'b1;
  logic [31:0] fetch_instr, fetch_pc;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fetch_misalign;
`endif

  int total = 0, bad = 0, cyc = 0, lat = 1;

  typedef struct { logic [31:0] a; int due; } bq_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } pop_t;
  bq_t         bq[$];
  pop_t        pop_log[$];
  logic [31:0] req_log[$];
  int          req_cyc[$];

  instr_prefetch #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .fetch_valid    (fetch_valid),
    .fetch_ready    (fetch_ready),
    .fetch_instr    (fetch_instr),
    .fetch_pc       (fetch_pc),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .fetch_misalign (fetch_misalign)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Bus: present the oldest accepted request once its latency has elapsed.
  always @(posedge clk) begin
    #2;
    if (bq.size() != 0 && bq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = bq[0].a ^ K;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  end

  // Inputs are stable at the falling edge, so handshakes seen here are what the next edge sees.
  always @(negedge clk) begin
    if (rst) begin
      bq.delete();
    end else begin
      if (imem_rsp_valid && bq.size() != 0) void'(bq.pop_front());
      if (imem_req_valid && imem_req_ready) begin
        bq.push_back('{imem_req_addr, cyc + lat});
        req_log.push_back(imem_req_addr);
        req_cyc.push_back(cyc);
      end
      if (fetch_valid && fetch_ready && !redirect)
        pop_log.push_back('{fetch_pc, fetch_instr});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    pop_log.delete();
    req_log.delete();
    req_cyc.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect = 1'b0;
    tick(2);
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    @(negedge clk);
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid got=%0b exp=0", imem_req_valid); end
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL reset_fetch_valid got=%0b exp=0", fetch_valid); end
    tick(1);
    rst = 1'b0;
    clear_logs();
    @(negedge clk);
    total++; if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL reset_first_req got=%0b exp=1", imem_req_valid); end
    total++; if (imem_req_addr !== 32'h0) begin bad++; $display("FAIL reset_first_addr got=%h exp=00000000", imem_req_addr); end
  endtask

  task automatic test_stream();
    lat = 1; fetch_ready = 1'b1; imem_req_ready = 1'b1;
    do_reset();
    tick(12);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (req_log.size() <= i || req_log[i] !== 32'(4*i)) begin
        bad++; $display("FAIL stream_addr[%0d] got=%h exp=%h", i, (req_log.size() > i) ? req_log[i] : 32'hx, 32'(4*i));
      end
    end
    total++;
    if (req_cyc.size() < 5 || req_cyc[4] - req_cyc[0] != 4) begin
      bad++; $display("FAIL stream_back_to_back got_span=%0d exp=4", (req_cyc.size() >= 5) ? req_cyc[4] - req_cyc[0] : -1);
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (pop_log.size() <= i || pop_log[i].pc !== 32'(4*i) || pop_log[i].instr !== (32'(4*i) ^ K)) begin
        bad++; $display("FAIL stream_pop[%0d] got_pc=%h exp_pc=%h", i, (pop_log.size() > i) ? pop_log[i].pc : 32'hx, 32'(4*i));
      end
    end
  endtask

  task automatic test_backpressure();
    lat = 1; fetch_ready = 1'b0; imem_req_ready = 1'b1;
    do_reset();
    tick(10);
    @(negedge clk);
    total++; if (req_log.size() != 4) begin bad++; $display("FAIL bp_req_count got=%0d exp=4", req_log.size()); end
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL bp_req_valid got=%0b exp=0", imem_req_valid); end
    total++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h0 || fetch_instr !== K) begin
      bad++; $display("FAIL bp_head got_v=%0b pc=%h instr=%h exp_v=1 pc=00000000 instr=%h", fetch_valid, fetch_pc, fetch_instr, K);
    end
    tick(3);
    @(negedge clk);
    total++; if (fetch_pc !== 32'h0 || fetch_instr !== K) begin bad++; $display("FAIL bp_head_hold got=%h exp=00000000", fetch_pc); end
    fetch_ready = 1'b1;
    tick(12);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (pop_log.size() <= i || pop_log[i].pc !== 32'(4*i)) begin
        bad++; $display("FAIL bp_drain[%0d] got=%h exp=%h", i, (pop_log.size() > i) ? pop_log[i].pc : 32'hx, 32'(4*i));
      end
    end
    total++; if (req_log.size() < 5 || req_log[4] !== 32'h10) begin
      bad++; $display("FAIL bp_resume got=%h exp=00000010", (req_log.size() >= 5) ? req_log[4] : 32'hx);
    end
  endtask

  task automatic test_redirect_inflight();
    lat = 3; fetch_ready = 1'b1; imem_req_ready = 1'b1;
    do_reset();
    tick(2);
    redirect = 1'b1; redirect_pc = 32'h100;
    clear_logs();
    @(negedge clk);
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL redir_req_blocked got=%0b exp=0", imem_req_valid); end
    total++; if (bq.size() != 2) begin bad++; $display("FAIL redir_two_inflight got=%0d exp=2", bq.size()); end
    tick(1);
    redirect = 1'b0;
    tick(20);
    total++; if (req_log.size() < 1 || req_log[0] !== 32'h100) begin
      bad++; $display("FAIL redir_first_req got=%h exp=00000100", (req_log.size() >= 1) ? req_log[0] : 32'hx);
    end
    total++; if (pop_log.size() < 2 || pop_log[0].pc !== 32'h100 || pop_log[0].instr !== (32'h100 ^ K)) begin
      bad++; $display("FAIL redir_pop0 got=%h exp=00000100", (pop_log.size() >= 1) ? pop_log[0].pc : 32'hx);
    end
    total++; if (pop_log.size() < 2 || pop_log[1].pc !== 32'h104) begin
      bad++; $display("FAIL redir_pop1 got=%h exp=00000104", (pop_log.size() >= 2) ? pop_log[1].pc : 32'hx);
    end
  endtask

  task automatic test_redirect_collide();
    lat = 1; fetch_ready = 1'b1; imem_req_ready = 1'b1;
    do_reset();
    tick(6);
    redirect = 1'b1; redirect_pc = 32'h200;
    clear_logs();
    @(negedge clk);
    total++; if (imem_rsp_valid !== 1'b1 || fetch_valid !== 1'b1) begin
      bad++; $display("FAIL collide_setup got_rsp=%0b got_fv=%0b exp=1 1", imem_rsp_valid, fetch_valid);
    end
    tick(1);
    redirect = 1'b0;
    @(negedge clk);
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL collide_empty got=%0b exp=0", fetch_valid); end
    tick(10);
    total++; if (pop_log.size() < 2 || pop_log[0].pc !== 32'h200 || pop_log[1].pc !== 32'h204) begin
      bad++; $display("FAIL collide_newpath got=%h exp=00000200", (pop_log.size() >= 1) ? pop_log[0].pc : 32'hx);
    end
  endtask

  task automatic test_wrap();
    lat = 1; fetch_ready = 1'b1; imem_req_ready = 1'b1;
    do_reset();
    tick(4);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    clear_logs();
    tick(1);
    redirect = 1'b0;
    tick(10);
    total++; if (req_log.size() < 3 || req_log[2] !== 32'h0) begin
      bad++; $display("FAIL wrap_req got=%h exp=00000000", (req_log.size() >= 3) ? req_log[2] : 32'hx);
    end
    total++; if (pop_log.size() < 4 || pop_log[1].pc !== 32'hFFFF_FFFC || pop_log[2].pc !== 32'h0 || pop_log[3].pc !== 32'h4) begin
      bad++; $display("FAIL wrap_pop got=%h exp=00000000", (pop_log.size() >= 3) ? pop_log[2].pc : 32'hx);
    end
  endtask

  task automatic test_req_stall();
    lat = 1; fetch_ready = 1'b1; imem_req_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
        bad++; $display("FAIL stall_hold[%0d] got_v=%0b addr=%h exp=1 00000000", i, imem_req_valid, imem_req_addr);
      end
      tick(1);
    end
    imem_req_ready = 1'b1;
    tick(1);
    @(negedge clk);
    total++; if (imem_req_addr !== 32'h4) begin bad++; $display("FAIL stall_advance got=%h exp=00000004", imem_req_addr); end
  endtask

  task automatic test_misalign();
    lat = 1; fetch_ready = 1'b1; imem_req_ready = 1'b1;
    do_reset();
    tick(5);
    redirect = 1'b1; redirect_pc = 32'h102;
    clear_logs();
    tick(1);
    redirect = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    @(negedge clk);
    total++; if (fetch_misalign !== 1'b1) begin bad++; $display("FAIL misalign_flag got=%0b exp=1", fetch_misalign); end
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL misalign_req got=%0b exp=0", imem_req_valid); end
    tick(10);
    @(negedge clk);
    total++; if (fetch_valid !== 1'b0 || req_log.size() != 0) begin
      bad++; $display("FAIL misalign_stall got_fv=%0b reqs=%0d exp=0 0", fetch_valid, req_log.size());
    end
`else
    tick(10);
    total++; if (req_log.size() < 1 || req_log[0] !== 32'h100) begin
      bad++; $display("FAIL align_req got=%h exp=00000100", (req_log.size() >= 1) ? req_log[0] : 32'hx);
    end
    total++; if (pop_log.size() < 1 || pop_log[0].pc !== 32'h100) begin
      bad++; $display("FAIL align_pop got=%h exp=00000100", (pop_log.size() >= 1) ? pop_log[0].pc : 32'hx);
    end
`endif
  endtask

  task automatic test_reset_mid();
    lat = 2; fetch_ready = 1'b0; imem_req_ready = 1'b1;
    do_reset();
    tick(8);
    rst = 1'b1;
    @(negedge clk);
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL midrst_req got=%0b exp=0", imem_req_valid); end
    tick(1);
    @(negedge clk);
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL midrst_fv got=%0b exp=0", fetch_valid); end
    tick(1);
    rst = 1'b0;
    fetch_ready = 1'b1;
    clear_logs();
    tick(12);
    total++; if (req_log.size() < 1 || req_log[0] !== 32'h0 || pop_log.size() < 1 || pop_log[0].pc !== 32'h0) begin
      bad++; $display("FAIL midrst_restart got=%h exp=00000000", (pop_log.size() >= 1) ? pop_log[0].pc : 32'hx);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_collide();
    test_wrap();
    test_req_stall();
    test_misalign();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
